// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD card SPI byte engine.
package sd_spi_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_e;

  localparam int         DIV_W     = 8;
  localparam int         BYTE_BITS = 8;
  localparam logic [7:0] RST_BYTE  = 8'hFF;
endpackage

// File: rtl/sd_spi_master_if.sv
// Byte handshake between the Z80 SD port block (slave side) and the SPI engine (master side).
// sd_slow exists only when SD_SPI_SLOW_EN is defined.
interface sd_spi_master_if;
  import sd_spi_pkg::*;

  logic                 sd_start;
  logic [BYTE_BITS-1:0] sd_datain;
  logic [BYTE_BITS-1:0] sd_dataout;
  logic                 sd_busy;
  logic                 sd_done;
`ifdef SD_SPI_SLOW_EN
  logic                 sd_slow;

  modport master (input sd_start, sd_datain, sd_slow, output sd_dataout, sd_busy, sd_done);
  modport slave  (output sd_start, sd_datain, sd_slow, input sd_dataout, sd_busy, sd_done);
`else
  modport master (input sd_start, sd_datain, output sd_dataout, sd_busy, sd_done);
  modport slave  (output sd_start, sd_datain, input sd_dataout, sd_busy, sd_done);
`endif
endinterface

// File: rtl/sd_spi_tick.sv
// Half-period divider: one-cycle tick when the count reaches half_i-1, then restarts from zero.
module sd_spi_tick
  import sd_spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] half_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q;

  assign tick_o = !clr_i && (cnt_q == half_i - DIV_W'(1));

  always_ff @(posedge clk) begin
    if (rst || clr_i || tick_o) cnt_q <= '0;
    else                        cnt_q <= cnt_q + DIV_W'(1);
  end

endmodule

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte engine for the SD port: 8 bits MSB-first, sdclk idle low.
// Optional SD_SPI_SLOW_EN adds sd_slow, selecting SLOW_HALF_DIV for a whole byte.
module sd_spi_master
  import sd_spi_pkg::*;
#(
  parameter int HALF_DIV = 2
`ifdef SD_SPI_SLOW_EN
  , parameter int SLOW_HALF_DIV = 64
`endif
) (
  input  logic            fclk,
  input  logic            rst,
  sd_spi_master_if.master sd,
  output logic            sdclk,
  output logic            sddo,
  input  logic            sddi
);

  state_e                 state_q;
  logic                   sdclk_q, busy_q, done_q, sddi_r, tick;
  logic [BYTE_BITS-1:0]   txsh_q, dataout_q;
  logic [BYTE_BITS-2:0]   rxsh_q;
  logic [2:0]             bitcnt_q;
  logic [DIV_W-1:0]       half;

`ifdef SD_SPI_SLOW_EN
  logic slow_q;

  always_ff @(posedge fclk) begin
    if (rst)                               slow_q <= 1'b0;
    else if (state_q == IDLE && sd.sd_start) slow_q <= sd.sd_slow;
  end

  assign half = slow_q ? DIV_W'(SLOW_HALF_DIV) : DIV_W'(HALF_DIV);
`else
  assign half = DIV_W'(HALF_DIV);
`endif

  always_ff @(posedge fclk) sddi_r <= sddi;

  sd_spi_tick u_tick (
    .clk    (fclk),
    .rst    (rst),
    .clr_i  (state_q == IDLE),
    .half_i (half),
    .tick_o (tick)
  );

  // MOSI is the MSB of txsh; it refills with ones so the line idles high.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q   <= IDLE;
      sdclk_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dataout_q <= RST_BYTE;
      txsh_q    <= RST_BYTE;
      rxsh_q    <= '1;
      bitcnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (sd.sd_start) begin
          txsh_q   <= sd.sd_datain;
          bitcnt_q <= '0;
          busy_q   <= 1'b1;
          state_q  <= LOW;
        end
        LOW: if (tick) begin
          sdclk_q <= 1'b1;
          state_q <= HIGH;
        end
        HIGH: if (tick) begin
          sdclk_q <= 1'b0;
          rxsh_q  <= {rxsh_q[BYTE_BITS-3:0], sddi_r};
          if (bitcnt_q == 3'(BYTE_BITS - 1)) begin
            dataout_q <= {rxsh_q, sddi_r};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            txsh_q    <= RST_BYTE;
            state_q   <= IDLE;
          end else begin
            txsh_q   <= {txsh_q[BYTE_BITS-2:0], 1'b1};
            bitcnt_q <= bitcnt_q + 3'd1;
            state_q  <= LOW;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sdclk         = sdclk_q;
  assign sddo          = txsh_q[BYTE_BITS-1];
  assign sd.sd_busy    = busy_q;
  assign sd.sd_done    = done_q;
  assign sd.sd_dataout = dataout_q;

endmodule

// File: tb/tb_sd_spi_master.sv
// Bench for sd_spi_master: loopback or shifting MISO slave, timing and data checked per byte.
// Covers the SD_SPI_SLOW_EN build when that macro is defined.
module tb_sd_spi_master;
  localparam int H = 2;
`ifdef SD_SPI_SLOW_EN
  localparam int SH = 64;
`endif

  logic       fclk = 1'b0;
  logic       rst;
  logic       sdclk, sddo, sddi;
  logic       lb, slave_load, sdclk_d;
  logic [7:0] slave_val, slave_sh;
  int         checks = 0;
  int         errors = 0;

  sd_spi_master_if bus ();

  sd_spi_master #(
    .HALF_DIV(H)
`ifdef SD_SPI_SLOW_EN
    , .SLOW_HALF_DIV(SH)
`endif
  ) dut (
    .fclk  (fclk),
    .rst   (rst),
    .sd    (bus),
    .sdclk (sdclk),
    .sddo  (sddo),
    .sddi  (sddi)
  );

  always #5 fclk = ~fclk;

  // MISO device: presents its MSB at start, shifts after each falling sdclk.
  assign sddi = lb ? sddo : slave_sh[7];
  always @(posedge fclk) begin
    sdclk_d <= sdclk;
    if (slave_load)            slave_sh <= slave_val;
    else if (sdclk_d && !sdclk) slave_sh <= {slave_sh[6:0], 1'b1};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One byte from start pulse to sd_done; start is issued in the current cycle when now=1.
  task automatic run_byte(input logic [7:0] tx, input logic [7:0] miso, input bit loopb,
                          input bit slow, input bit now, input int inj_at);
    int         hp, lat, nrise, first_rise, last_rise, hi_cnt;
    bit         busy_ok, saw_low;
    logic [7:0] mosi_bits, exp_rx;
    logic       prev;
    hp = H;
`ifdef SD_SPI_SLOW_EN
    if (slow) hp = SH;
`endif
    exp_rx = loopb ? tx : miso;
    if (!now) @(negedge fclk);
    lb = loopb; slave_val = miso; slave_load = 1'b1;
    bus.sd_start = 1'b1; bus.sd_datain = tx;
`ifdef SD_SPI_SLOW_EN
    bus.sd_slow = slow;
`endif
    @(negedge fclk);
    bus.sd_start = 1'b0; slave_load = 1'b0; bus.sd_datain = 8'($urandom);
`ifdef SD_SPI_SLOW_EN
    bus.sd_slow = ~slow;
`endif
    lat = 0; nrise = 0; first_rise = 0; last_rise = 0; hi_cnt = 0;
    busy_ok = 1'b1; saw_low = 1'b0; mosi_bits = '0; prev = sdclk;
    for (int i = 1; i <= 16 * hp + 8; i++) begin
      if (sdclk && !prev) begin
        nrise++;
        if (nrise == 1) first_rise = i;
        last_rise = i;
        mosi_bits = {mosi_bits[6:0], sddo};
      end
      if (sdclk) hi_cnt++;
      prev = sdclk;
      if (!sddo) saw_low = 1'b1;
      if (bus.sd_done) begin
        lat = i;
        bus.sd_start = 1'b0;
        break;
      end
      if (!bus.sd_busy) busy_ok = 1'b0;
      bus.sd_start = (i == inj_at);
      bus.sd_datain = (i == inj_at) ? 8'h00 : bus.sd_datain;
      @(negedge fclk);
    end
    chk("latency", lat, 16 * hp + 1);
    chk("busy_during", busy_ok, 1);
    chk("busy_end", bus.sd_busy, 0);
    chk("dataout", bus.sd_dataout, exp_rx);
    chk("sdclk_rises", nrise, 8);
    chk("mosi_bits", mosi_bits, tx);
    chk("first_rise", first_rise, hp + 1);
    chk("last_rise", last_rise, 15 * hp + 1);
    chk("high_cycles", hi_cnt, 8 * hp);
    chk("sddo_end", sddo, 1);
    if (tx == 8'hFF) chk("mosi_stays_high", saw_low, 0);
  endtask

  task automatic idle_chk(input int n, input logic [7:0] hold);
    int   r, d, b;
    logic prev;
    r = 0; d = 0; b = 0; prev = sdclk;
    for (int i = 0; i < n; i++) begin
      @(negedge fclk);
      if (sdclk && !prev) r++;
      prev = sdclk;
      if (bus.sd_done) d++;
      if (bus.sd_busy) b++;
    end
    chk("idle_rises", r, 0);
    chk("idle_done", d, 0);
    chk("idle_busy", b, 0);
    chk("idle_hold", bus.sd_dataout, hold);
  endtask

  initial begin
    rst = 1'b1; lb = 1'b1; slave_load = 1'b0; slave_val = 8'hFF;
    bus.sd_start = 1'b0; bus.sd_datain = 8'h00;
`ifdef SD_SPI_SLOW_EN
    bus.sd_slow = 1'b0;
`endif
    repeat (3) @(negedge fclk);
    chk("rst_sdclk", sdclk, 0);
    chk("rst_sddo", sddo, 1);
    chk("rst_busy", bus.sd_busy, 0);
    chk("rst_done", bus.sd_done, 0);
    chk("rst_dataout", bus.sd_dataout, 8'hFF);
    rst = 1'b0;

    run_byte(8'hA5, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    idle_chk(5, 8'hA5);
    run_byte(8'hFF, 8'h3C, 1'b0, 1'b0, 1'b0, 0);
    idle_chk(5, 8'h3C);
    run_byte(8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 10);
    idle_chk(40, 8'h81);
    run_byte(8'h12, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    run_byte(8'h34, 8'h00, 1'b1, 1'b0, 1'b1, 0);
    idle_chk(5, 8'h34);

    // Abort mid-byte with reset during cycle 12.
    @(negedge fclk);
    lb = 1'b1; bus.sd_start = 1'b1; bus.sd_datain = 8'h96;
    @(negedge fclk);
    bus.sd_start = 1'b0;
    repeat (11) @(negedge fclk);
    rst = 1'b1;
    @(negedge fclk);
    chk("abort_sdclk", sdclk, 0);
    chk("abort_sddo", sddo, 1);
    chk("abort_busy", bus.sd_busy, 0);
    chk("abort_done", bus.sd_done, 0);
    chk("abort_dataout", bus.sd_dataout, 8'hFF);
    rst = 1'b0;
    idle_chk(40, 8'hFF);
    run_byte(8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    idle_chk(5, 8'h5A);

    for (int k = 0; k < 8; k++) begin
      run_byte(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 30)));
    end
    idle_chk(5, bus.sd_dataout);

`ifdef SD_SPI_SLOW_EN
    run_byte(8'hC3, 8'h00, 1'b1, 1'b1, 1'b0, 0);
    idle_chk(5, 8'hC3);
    run_byte(8'hC3, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    idle_chk(5, 8'hC3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
